// File: rtl/tag_slot_scheduler.sv
// TDMA frame scheduler for the backscatter tag control lines.
// Each frame gives every enabled tag a one-hot enable window of slot_len
// cycles. Consecutive enabled slots are separated by guard_len idle cycles,
// and the frame ends with a cold_len cooldown. Configuration is captured into
// shadow registers at start and at every frame restart, so input changes made
// mid-frame do not disturb the frame that is already running.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no frame running, tag_en = 0, waiting for start
//   S_SLOT  | tag_en = onehot(cur_tag) for slot_len cycles
//   S_GUARD | tag_en = 0 for guard_len cycles between two enabled slots
//   S_COLD  | tag_en = 0 for cold_len cycles after the last slot of a frame
//
// Every timer is a down-counter. It is loaded with len-1, and the phase ends on
// the cycle where the count reads zero.
module tag_slot_scheduler #(
   parameter int TAG_NUM = 4,
   parameter int CNT_W   = 32,
   parameter int FCNT_W  = 16,
   parameter int IDX_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               abort,
   input  logic               continuous,
   input  logic [TAG_NUM-1:0] tag_mask,
   input  logic [CNT_W-1:0]   slot_len,
   input  logic [CNT_W-1:0]   guard_len,
   input  logic [CNT_W-1:0]   cold_len,
   output logic [TAG_NUM-1:0] tag_en,
   output logic [IDX_W-1:0]   cur_tag,
   output logic               busy,
   output logic               frame_done,
   output logic [FCNT_W-1:0]  frame_cnt,
   output logic               cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SLOT  = 2'd1,
      S_GUARD = 2'd2,
      S_COLD  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Shadow copy of the configuration that the running frame uses.
   logic [TAG_NUM-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]   slot_q, slot_d;
   logic [CNT_W-1:0]   guard_q, guard_d;
   logic [CNT_W-1:0]   cold_q, cold_d;
   logic               cont_q, cont_d;

   logic               stop_pend_q, stop_pend_d;
   logic [IDX_W-1:0]   cur_q, cur_d;

   // Registered outputs.
   logic [TAG_NUM-1:0] tag_en_q, tag_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cerr_q, cerr_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

   logic               cfg_ok;
   logic [IDX_W-1:0]   first_idx;
   logic               has_next;
   logic [IDX_W-1:0]   next_idx;
   logic               frame_end;
   logic               relatch;
   logic               stop_eff;

   // Return the index of the lowest set bit of m. Returns 0 if m is empty.
   // Callers only use the result after the mask has been validated.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [TAG_NUM-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = TAG_NUM - 1; i >= 0; i--) begin
         if (m[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // Check the incoming configuration and pick the first tag it would schedule.
   always_comb begin
      cfg_ok    = (slot_len != '0) && (tag_mask != '0);
      first_idx = lowest_set(tag_mask);
   end

   // Find the next enabled tag above cur_tag in the shadow mask.
   always_comb begin
      has_next = 1'b0;
      next_idx = cur_q;
      for (int i = TAG_NUM - 1; i >= 0; i--) begin
         if (mask_q[i] && (i > int'(cur_q))) begin
            has_next = 1'b1;
            next_idx = IDX_W'(i);
         end
      end
   end

   // Next-state logic, timers, frame bookkeeping and the config latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mask_d      = mask_q;
      slot_d      = slot_q;
      guard_d     = guard_q;
      cold_d      = cold_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      cur_d       = cur_q;
      done_d      = 1'b0;
      cerr_d      = 1'b0;
      fcnt_d      = fcnt_q;
      frame_end   = 1'b0;
      relatch     = 1'b0;
      // A stop that arrives on the final cycle of a frame still counts for that frame.
      stop_eff    = stop_pend_q | stop;

      if (abort && (state_q != S_IDLE)) begin
         // abort wins over stop and over a frame end in the same cycle.
         state_d     = S_IDLE;
         stop_pend_d = 1'b0;
      end else begin
         if (stop && (state_q != S_IDLE)) stop_pend_d = 1'b1;

         unique case (state_q)
            S_IDLE: begin
               if (start && !stop && !abort) relatch = 1'b1;
            end
            S_SLOT: begin
               if (cnt_q == '0) begin
                  if (has_next) begin
                     if (guard_q != '0) begin
                        state_d = S_GUARD;
                        cnt_d   = guard_q - CNT_W'(1);
                     end else begin
                        state_d = S_SLOT;
                        cur_d   = next_idx;
                        cnt_d   = slot_q - CNT_W'(1);
                     end
                  end else if (cold_q != '0) begin
                     state_d = S_COLD;
                     cnt_d   = cold_q - CNT_W'(1);
                  end else begin
                     frame_end = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_GUARD: begin
               if (cnt_q == '0) begin
                  state_d = S_SLOT;
                  cur_d   = next_idx;
                  cnt_d   = slot_q - CNT_W'(1);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_COLD: begin
               if (cnt_q == '0) frame_end = 1'b1;
               else             cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
         endcase

         if (frame_end) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + FCNT_W'(1);
            if (cont_q && !stop_eff) begin
               relatch = 1'b1;
            end else begin
               state_d     = S_IDLE;
               stop_pend_d = 1'b0;
            end
         end

         // Starting or restarting a frame copies the live config into the shadow registers.
         if (relatch) begin
            if (cfg_ok) begin
               mask_d  = tag_mask;
               slot_d  = slot_len;
               guard_d = guard_len;
               cold_d  = cold_len;
               cont_d  = continuous;
               cur_d   = first_idx;
               cnt_d   = slot_len - CNT_W'(1);
               state_d = S_SLOT;
            end else begin
               cerr_d      = 1'b1;
               state_d     = S_IDLE;
               stop_pend_d = 1'b0;
            end
         end
      end

      tag_en_d = (state_d == S_SLOT) ? (TAG_NUM'(1) << cur_d) : '0;
      busy_d   = (state_d != S_IDLE);
   end

   // State, shadow configuration and output registers, with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mask_q      <= '0;
         slot_q      <= '0;
         guard_q     <= '0;
         cold_q      <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         cur_q       <= '0;
         tag_en_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cerr_q      <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mask_q      <= mask_d;
         slot_q      <= slot_d;
         guard_q     <= guard_d;
         cold_q      <= cold_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         cur_q       <= cur_d;
         tag_en_q    <= tag_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cerr_q      <= cerr_d;
         fcnt_q      <= fcnt_d;
      end
   end

   assign tag_en     = tag_en_q;
   assign cur_tag    = cur_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   assign frame_cnt  = fcnt_q;
   assign cfg_err    = cerr_q;

endmodule

// File: tb/tb_tag_slot_scheduler.sv
// Scoreboard bench for tag_slot_scheduler.
// Stimulus pushes the expected output events before each frame is started.
// Three kinds of event are expected:
//   - a busy run of constant tag_en, with its length,
//   - a frame_done pulse, with the frame_cnt value,
//   - a cfg_err pulse.
// A monitor samples the outputs on the falling edge, turns them into the same
// events, and checks each one against the front of the queue.
module tb_tag_slot_scheduler;
   localparam int TAG_NUM = 4;
   localparam int CNT_W   = 32;
   localparam int FCNT_W  = 2;
   localparam int IDX_W   = 2;

   localparam int EV_SEG  = 0;
   localparam int EV_DONE = 1;
   localparam int EV_CERR = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               abort = 1'b0;
   logic               continuous = 1'b0;
   logic [TAG_NUM-1:0] tag_mask = '0;
   logic [CNT_W-1:0]   slot_len = '0;
   logic [CNT_W-1:0]   guard_len = '0;
   logic [CNT_W-1:0]   cold_len = '0;
   logic [TAG_NUM-1:0] tag_en;
   logic [IDX_W-1:0]   cur_tag;
   logic               busy;
   logic               frame_done;
   logic [FCNT_W-1:0]  frame_cnt;
   logic               cfg_err;

   tag_slot_scheduler #(
      .TAG_NUM(TAG_NUM), .CNT_W(CNT_W), .FCNT_W(FCNT_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
      .continuous(continuous), .tag_mask(tag_mask), .slot_len(slot_len),
      .guard_len(guard_len), .cold_len(cold_len), .tag_en(tag_en),
      .cur_tag(cur_tag), .busy(busy), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int val;
      int len;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_errors = 0;
   int  exp_fcnt = 0;
   bit  mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input int val, input int len);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.len  = len;
      exp_q.push_back(e);
   endtask

   task automatic push_seg(input int val, input int len);
      push_ev(EV_SEG, val, len);
   endtask

   task automatic push_done();
      exp_fcnt = (exp_fcnt + 1) % 4;
      push_ev(EV_DONE, exp_fcnt, 0);
   endtask

   task automatic mon_event(input int kind, input int val, input int len);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL event: got kind=%0d val=%0d len=%0d, expected none", kind, val, len);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.len != len) begin
            n_errors++;
            $display("FAIL event: got kind=%0d val=%0d len=%0d, expected kind=%0d val=%0d len=%0d",
                     kind, val, len, e.kind, e.val, e.len);
         end
      end
   endtask

   // Falling-edge monitor. It closes a run whenever {busy, tag_en} changes and
   // only reports runs that happened while busy was high.
   initial begin
      logic [4:0] key_prev;
      int         run_len;
      key_prev = '0;
      run_len  = 0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            n_checks++;
            if (!$onehot0(tag_en)) begin
               n_errors++;
               $display("FAIL onehot: tag_en=%b, expected at most one bit set", tag_en);
            end
            if ({busy, tag_en} != key_prev) begin
               if (key_prev[4]) mon_event(EV_SEG, int'(key_prev[3:0]), run_len);
               key_prev = {busy, tag_en};
               run_len  = 1;
            end else begin
               run_len++;
            end
            if (frame_done) mon_event(EV_DONE, int'(frame_cnt), 0);
            if (cfg_err)    mon_event(EV_CERR, 0, 0);
         end else begin
            key_prev = {busy, tag_en};
            run_len  = 0;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg(input logic [3:0] m, input int s, input int g, input int c, input logic cont);
      tag_mask   = m;
      slot_len   = s;
      guard_len  = g;
      cold_len   = c;
      continuous = cont;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while (busy && c < 20000) begin
         tick();
         c++;
      end
      chk(name, int'(busy), 0);
   endtask

   task automatic wait_tag(input int val, input string name);
      int c;
      c = 0;
      while (int'(tag_en) != val && c < 2000) begin
         tick();
         c++;
      end
      chk(name, int'(tag_en), val);
   endtask

   task automatic wait_done(input string name);
      int c;
      c = 0;
      while (!frame_done && c < 2000) begin
         tick();
         c++;
      end
      chk(name, int'(frame_done), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      tick(3);
      rst = 1'b0;
      chk("reset tag_en", int'(tag_en), 0);
      chk("reset cur_tag", int'(cur_tag), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset frame_done", int'(frame_done), 0);
      chk("reset frame_cnt", int'(frame_cnt), 0);
      chk("reset cfg_err", int'(cfg_err), 0);
      mon_en = 1'b1;

      // In IDLE, stop and abort do nothing, and start is ignored when it
      // arrives together with stop or abort.
      cfg(4'b1111, 800, 0, 800, 1'b0);
      stop = 1'b1;  tick(); stop = 1'b0;
      abort = 1'b1; tick(); abort = 1'b0;
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      start = 1'b1; stop = 1'b1;  tick(); start = 1'b0; stop = 1'b0;
      tick(2);
      chk("idle ignores ctl busy", int'(busy), 0);

      // Basic frame. A second start mid-frame must be ignored.
      push_seg(1, 800); push_seg(2, 800); push_seg(4, 800); push_seg(8, 800);
      push_seg(0, 800); push_done();
      pulse_start();
      chk("basic latency tag_en", int'(tag_en), 1);
      chk("basic busy", int'(busy), 1);
      tick(100);
      pulse_start();
      wait_idle("basic end");
      chk("basic frame_cnt", int'(frame_cnt), 1);

      // Masked tags with guard gaps.
      cfg(4'b1010, 5, 3, 2, 1'b0);
      push_seg(2, 5); push_seg(0, 3); push_seg(8, 5); push_seg(0, 2); push_done();
      pulse_start();
      chk("mask first cur_tag", int'(cur_tag), 1);
      wait_idle("mask end");
      chk("mask frame_cnt", int'(frame_cnt), 2);
      chk("mask cur_tag held", int'(cur_tag), 3);

      // Continuous mode, then a graceful stop during frame 2.
      cfg(4'b1111, 4, 0, 4, 1'b1);
      for (int f = 0; f < 2; f++) begin
         push_seg(1, 4); push_seg(2, 4); push_seg(4, 4); push_seg(8, 4);
         push_seg(0, 4); push_done();
      end
      pulse_start();
      wait_done("cont frame1 done");
      tick(5);
      stop = 1'b1; tick(); stop = 1'b0;
      wait_idle("cont end");
      chk("cont frame_cnt", int'(frame_cnt), 0);
      continuous = 1'b0;

      // Abort during the tag-2 slot.
      cfg(4'b1111, 6, 2, 3, 1'b0);
      push_seg(1, 6); push_seg(0, 2); push_seg(2, 6); push_seg(0, 2); push_seg(4, 3);
      pulse_start();
      wait_tag(4, "abort reach tag2");
      tick(2);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("abort tag_en", int'(tag_en), 0);
      chk("abort busy", int'(busy), 0);
      chk("abort frame_cnt", int'(frame_cnt), 0);

      // A fresh start after the abort must begin cleanly at tag 0.
      cfg(4'b1111, 2, 0, 1, 1'b0);
      push_seg(1, 2); push_seg(2, 2); push_seg(4, 2); push_seg(8, 2); push_seg(0, 1); push_done();
      pulse_start();
      chk("restart cur_tag", int'(cur_tag), 0);
      chk("restart tag_en", int'(tag_en), 1);
      wait_idle("restart end");
      chk("restart frame_cnt", int'(frame_cnt), 1);

      // Config error: slot_len = 0.
      cfg(4'b1111, 0, 0, 2, 1'b0);
      push_ev(EV_CERR, 0, 0);
      pulse_start();
      chk("cfg slot0 cfg_err", int'(cfg_err), 1);
      chk("cfg slot0 busy", int'(busy), 0);
      tick();
      chk("cfg slot0 pulse", int'(cfg_err), 0);

      // Config error at re-latch: mask cleared while a continuous frame is running.
      cfg(4'b1111, 3, 0, 2, 1'b1);
      push_seg(1, 3); push_seg(2, 3); push_seg(4, 3); push_seg(8, 3); push_seg(0, 2);
      push_done(); push_ev(EV_CERR, 0, 0);
      pulse_start();
      wait_tag(2, "relatch reach tag1");
      tag_mask = 4'b0000;
      wait_idle("relatch end");
      chk("relatch frame_cnt", int'(frame_cnt), 2);
      cfg(4'b1111, 3, 0, 2, 1'b0);

      // Reset in the middle of a slot.
      cfg(4'b1111, 10, 0, 0, 1'b0);
      push_seg(1, 10); push_seg(2, 3);
      pulse_start();
      wait_tag(2, "reset reach tag1");
      tick(2);
      rst = 1'b1; tick(); 
      chk("midrst tag_en", int'(tag_en), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst cur_tag", int'(cur_tag), 0);
      chk("midrst frame_cnt", int'(frame_cnt), 0);
      rst = 1'b0;
      exp_fcnt = 0;

      // Five single-tag frames with a 2-bit frame_cnt, which wraps to end at 1.
      // guard_len is nonzero, but a single-tag mask must never produce a guard.
      cfg(4'b0001, 2, 3, 1, 1'b0);
      for (int f = 0; f < 5; f++) begin
         push_seg(1, 2); push_seg(0, 1); push_done();
         pulse_start();
         wait_idle("wrap frame end");
      end
      chk("wrap frame_cnt", int'(frame_cnt), 1);

      tick(5);
      chk("queue drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
